// File: rtl/ysyx_2022040010_dmem_arb.sv
// Shared data-memory arbiter: instruction fetch and load/store onto one port.
// Each access runs grant -> address handshake -> data return -> response.
module ysyx_2022040010_dmem_arb #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_req,
    output logic                  err
);

    localparam int         MASK_W = DATA_W / 8;
    localparam logic [7:0] TMO    = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mreq_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    mreq_t             req_q, req_d;
    logic [7:0]        timer_q, timer_d;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
    logic              cap_en;
    logic [DATA_W-1:0] cap_data;
    logic              in_req;
    logic              in_resp;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        req_d    = req_q;
        timer_d  = timer_q;
        if_gnt   = 1'b0;
        ls_gnt   = 1'b0;
        err      = 1'b0;
        cap_en   = 1'b0;
        cap_data = '0;
        unique case (state_q)
            S_IDLE: begin
                // LS is the older instruction, so it wins a tie
                if (ls_req) begin
                    ls_gnt      = 1'b1;
                    owner_d     = OWN_LS;
                    req_d.we    = ls_we;
                    req_d.addr  = ls_addr;
                    req_d.wdata = ls_we ? ls_wdata : '0;
                    req_d.wmask = ls_we ? ls_wmask : '0;
                    state_d     = S_REQ;
                end else if (if_req) begin
                    if_gnt      = 1'b1;
                    owner_d     = OWN_IF;
                    req_d.we    = 1'b0;
                    req_d.addr  = if_addr;
                    req_d.wdata = '0;
                    req_d.wmask = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (req_q.we) begin
                        cap_en  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        timer_d = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    cap_en   = 1'b1;
                    cap_data = mem_rdata;
                    state_d  = S_RESP;
                end else if (timer_q == TMO) begin
                    err     = 1'b1;
                    cap_en  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESP: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            if_gnt = 1'b0;
            ls_gnt = 1'b0;
            err    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_NONE;
            req_q      <= '0;
            timer_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            timer_q <= timer_d;
            if (cap_en) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= cap_data;
                end else begin
                    ls_rdata_q <= cap_data;
                end
            end
        end
    end

    // Memory-side fields are only driven while a request is outstanding
    assign in_req    = (state_q == S_REQ);
    assign in_resp   = (state_q == S_RESP);
    assign mem_req   = in_req;
    assign mem_we    = in_req & req_q.we;
    assign mem_addr  = in_req ? req_q.addr  : '0;
    assign mem_wdata = in_req ? req_q.wdata : '0;
    assign mem_wmask = in_req ? req_q.wmask : '0;

    assign if_rvalid = in_resp & (owner_q == OWN_IF);
    assign ls_rvalid = in_resp & (owner_q == OWN_LS);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

    assign stall_req = (if_req & ~if_rvalid) | (ls_req & ~ls_rvalid);

endmodule

// File: tb/tb_ysyx_2022040010_dmem_arb.sv
// Bench for the IF/LS data-memory arbiter: directed scenarios then
// randomized traffic against a transaction-level memory/arbiter model.
module tb_ysyx_2022040010_dmem_arb;

    localparam logic [63:0] D_IF = 64'h0000_0013_0000_0093;
    localparam logic [63:0] D1   = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D2   = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] D3   = 64'h0BAD_F00D_0000_0001;
    localparam logic [63:0] D4   = 64'h7777_6666_5555_4444;
    localparam logic [63:0] WD   = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [63:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        stall_req;
    logic        err;

    int checks;
    int failures;

    ysyx_2022040010_dmem_arb #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .MAX_WAIT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wmask  (ls_wmask),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .stall_req (stall_req),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = '0;
        ls_wdata   = '0;
        ls_wmask   = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic test_reset();
        logic [270:0] all_o;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        all_o = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                 mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, err};
        checks++;
        if (all_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_o);
        end
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", stall_req);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_req got=%b exp=0", mem_req);
        end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_req    = 1'b1;
        if_addr   = 64'h8000_0000;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL ifrd_gnt got=%b exp=1", if_gnt);
        end
        checks++;
        if (stall_req !== 1'b1) begin
            failures++;
            $display("FAIL ifrd_stall got=%b exp=1", stall_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({if_gnt, mem_req, mem_we, mem_addr, mem_wmask} !==
            {1'b0, 1'b1, 1'b0, 64'h8000_0000, 8'h00}) begin
            failures++;
            $display("FAIL ifrd_memreq got=%b%b%b %h %h", if_gnt, mem_req,
                     mem_we, mem_addr, mem_wmask);
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = D_IF;
        #1;
        checks++;
        if (if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL ifrd_early_rvalid got=%b exp=0", if_rvalid);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '1;
        #1;
        checks++;
        if ({if_rvalid, if_rdata, err, stall_req} !== {1'b1, D_IF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ifrd_resp got=%b %h err=%b stall=%b exp=1 %h 0 0",
                     if_rvalid, if_rdata, err, stall_req, D_IF);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, D_IF}) begin
            failures++;
            $display("FAIL ifrd_hold got=%b %h exp=0 %h", if_rvalid, if_rdata, D_IF);
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            ls_req     = (k <= 3);
            ls_we      = 1'b0;
            ls_addr    = 64'h8000_1000;
            if_req     = (k <= 7);
            if_addr    = 64'h8000_0040;
            mem_ready  = 1'b1;
            mem_rvalid = (k == 2) || (k == 6);
            mem_rdata  = (k == 2) ? D1 : ((k == 6) ? D2 : '1);
            #1;
            checks++;
            if ({ls_gnt, if_gnt} !== {k == 0, k == 4}) begin
                failures++;
                $display("FAIL prio_gnt k=%0d got=%b%b exp=%b%b", k, ls_gnt,
                         if_gnt, k == 0, k == 4);
            end
            checks++;
            if ({ls_rvalid, if_rvalid} !== {k == 3, k == 7}) begin
                failures++;
                $display("FAIL prio_rvalid k=%0d got=%b%b exp=%b%b", k,
                         ls_rvalid, if_rvalid, k == 3, k == 7);
            end
            checks++;
            if (stall_req !== (k <= 6)) begin
                failures++;
                $display("FAIL prio_stall k=%0d got=%b exp=%b", k, stall_req, k <= 6);
            end
            checks++;
            if (mem_req !== ((k == 1) || (k == 5))) begin
                failures++;
                $display("FAIL prio_memreq k=%0d got=%b", k, mem_req);
            end
            if (k == 1 || k == 5) begin
                checks++;
                if (mem_addr !== ((k == 1) ? 64'h8000_1000 : 64'h8000_0040)) begin
                    failures++;
                    $display("FAIL prio_addr k=%0d got=%h", k, mem_addr);
                end
            end
            if (k == 3) begin
                checks++;
                if (ls_rdata !== D1) begin
                    failures++;
                    $display("FAIL prio_ls_data got=%h exp=%h", ls_rdata, D1);
                end
            end
            if (k == 7) begin
                checks++;
                if (if_rdata !== D2) begin
                    failures++;
                    $display("FAIL prio_if_data got=%h exp=%h", if_rdata, D2);
                end
            end
        end
    endtask

    task automatic test_store();
        bit exp_req;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            ls_req     = (k <= 5);
            ls_we      = 1'b1;
            ls_addr    = 64'h8000_2000;
            ls_wdata   = WD;
            ls_wmask   = 8'h0F;
            mem_ready  = (k >= 4);
            mem_rvalid = 1'b0;
            #1;
            exp_req = (k >= 1) && (k <= 4);
            checks++;
            if ({ls_gnt, mem_req, ls_rvalid} !== {k == 0, exp_req, k == 5}) begin
                failures++;
                $display("FAIL store_seq k=%0d got=%b%b%b exp=%b%b%b", k, ls_gnt,
                         mem_req, ls_rvalid, k == 0, exp_req, k == 5);
            end
            if (exp_req) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata, mem_wmask} !==
                    {1'b1, 64'h8000_2000, WD, 8'h0F}) begin
                    failures++;
                    $display("FAIL store_fields k=%0d got=%b %h %h %h", k, mem_we,
                             mem_addr, mem_wdata, mem_wmask);
                end
            end
            if (k == 5) begin
                checks++;
                if (ls_rdata !== 64'h0) begin
                    failures++;
                    $display("FAIL store_ack_data got=%h exp=0", ls_rdata);
                end
            end
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k <= 23; k++) begin
            @(negedge clk);
            ls_req     = (k <= 18);
            ls_we      = 1'b0;
            ls_addr    = 64'h8000_3000;
            if_req     = (k >= 19) && (k <= 22);
            if_addr    = 64'h8000_0080;
            mem_ready  = 1'b1;
            mem_rvalid = (k == 21);
            mem_rdata  = (k == 21) ? D3 : '0;
            #1;
            checks++;
            if (err !== (k == 17)) begin
                failures++;
                $display("FAIL tmo_err k=%0d got=%b exp=%b", k, err, k == 17);
            end
            checks++;
            if ({ls_gnt, ls_rvalid, if_gnt, if_rvalid} !==
                {k == 0, k == 18, k == 19, k == 22}) begin
                failures++;
                $display("FAIL tmo_hs k=%0d got=%b%b%b%b", k, ls_gnt, ls_rvalid,
                         if_gnt, if_rvalid);
            end
            checks++;
            if (mem_req !== ((k == 1) || (k == 20))) begin
                failures++;
                $display("FAIL tmo_memreq k=%0d got=%b", k, mem_req);
            end
            if (k == 18) begin
                checks++;
                if (ls_rdata !== 64'h0) begin
                    failures++;
                    $display("FAIL tmo_data got=%h exp=0", ls_rdata);
                end
            end
            if (k == 22) begin
                checks++;
                if (if_rdata !== D3) begin
                    failures++;
                    $display("FAIL tmo_after_if got=%h exp=%h", if_rdata, D3);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ls_req     = 1'b1;
        ls_we      = 1'b0;
        ls_addr    = 64'h8000_4000;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if (ls_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rstm_gnt got=%b exp=1", ls_gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstm_req_before got=%b exp=1", mem_req);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, ls_gnt} !== 2'b00) begin
            failures++;
            $display("FAIL rstm_async_drop got=%b%b exp=00", mem_req, ls_gnt);
        end
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({ls_gnt, if_rdata} !== {1'b1, 64'h0}) begin
            failures++;
            $display("FAIL rstm_regrant got=%b %h exp=1 0", ls_gnt, if_rdata);
        end
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, ls_rvalid, if_rvalid, err} !== 4'b0000) begin
            failures++;
            $display("FAIL rstm_wait_abort got=%b%b%b%b exp=0000", mem_req,
                     ls_rvalid, if_rvalid, err);
        end
        @(negedge clk);
        rst        = 1'b0;
        ls_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 2) mem_rvalid = 1'b0;
            #1;
            checks++;
            if ({ls_rvalid, if_rvalid, err, ls_rdata} !== {3'b000, 64'h0}) begin
                failures++;
                $display("FAIL rstm_late k=%0d got=%b%b%b %h exp=000 0", k,
                         ls_rvalid, if_rvalid, err, ls_rdata);
            end
        end
    endtask

    task automatic test_drop();
        @(negedge clk);
        if_req    = 1'b1;
        if_addr   = 64'h8000_0100;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL drop_gnt got=%b exp=1", if_gnt);
        end
        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 64'h8000_0100}) begin
            failures++;
            $display("FAIL drop_req got=%b %h", mem_req, mem_addr);
        end
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = D4;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            failures++;
            $display("FAIL drop_stall got=%b exp=0", stall_req);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, D4}) begin
            failures++;
            $display("FAIL drop_resp got=%b %h exp=1 %h", if_rvalid, if_rdata, D4);
        end
    endtask

    task automatic test_random();
        logic [63:0] mem [8];
        bit          busy, own_ls, hs_done, rd_pend, if_pend, ls_pend;
        bit          exp_lg, exp_ig, exp_mreq, exp_rv, exp_irv, exp_lrv, exp_stall;
        int          grant_cyc, rv_cyc, rd_due, d, t_idx, if_idx, ls_idx;
        logic        t_we;
        logic [63:0] t_addr, t_wdata, t_rdata, rd_data, last_if, last_ls;
        logic [7:0]  t_wmask;
        busy = 0; own_ls = 0; hs_done = 0; rd_pend = 0; if_pend = 0; ls_pend = 0;
        grant_cyc = 0; rv_cyc = -1; rd_due = 0; t_idx = 0; if_idx = 0; ls_idx = 0;
        t_we = 0; t_addr = '0; t_wdata = '0; t_rdata = '0; rd_data = '0; t_wmask = '0;
        last_if = D4;
        last_ls = 64'h0;
        for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc < 360) begin
                if (!if_pend && ($urandom_range(0, 2) == 0)) begin
                    if_pend = 1;
                    if_idx  = int'($urandom_range(0, 7));
                    if_addr = 64'h8000_0000 + 64'(if_idx * 8);
                end
                if (!ls_pend && ($urandom_range(0, 3) == 0)) begin
                    ls_pend  = 1;
                    ls_idx   = int'($urandom_range(0, 7));
                    ls_addr  = 64'h8000_0000 + 64'(ls_idx * 8);
                    ls_we    = 1'($urandom_range(0, 1));
                    ls_wdata = {$urandom, $urandom};
                    ls_wmask = 8'($urandom);
                end
            end
            if_req    = if_pend;
            ls_req    = ls_pend;
            mem_ready = ($urandom_range(0, 2) != 0);
            if (rd_pend && cyc == rd_due) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data;
            end else if (!rd_pend && ($urandom_range(0, 4) == 0)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {$urandom, $urandom};
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = {$urandom, $urandom};
            end
            #1;
            exp_lg = !busy && ls_req;
            exp_ig = !busy && !ls_req && if_req;
            checks++;
            if ({ls_gnt, if_gnt} !== {exp_lg, exp_ig}) begin
                failures++;
                $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", cyc, ls_gnt,
                         if_gnt, exp_lg, exp_ig);
            end
            if (exp_lg || exp_ig) begin
                busy      = 1;
                own_ls    = exp_lg;
                grant_cyc = cyc;
                hs_done   = 0;
                rv_cyc    = -1;
                if (exp_lg) begin
                    t_we    = ls_we;
                    t_addr  = ls_addr;
                    t_idx   = ls_idx;
                    t_wdata = ls_wdata;
                    t_wmask = ls_we ? ls_wmask : 8'h00;
                end else begin
                    t_we    = 1'b0;
                    t_addr  = if_addr;
                    t_idx   = if_idx;
                    t_wdata = '0;
                    t_wmask = 8'h00;
                end
            end
            exp_mreq = busy && !hs_done && (cyc > grant_cyc);
            checks++;
            if (mem_req !== exp_mreq) begin
                failures++;
                $display("FAIL rnd_memreq cyc=%0d got=%b exp=%b", cyc, mem_req, exp_mreq);
            end
            if (exp_mreq) begin
                checks++;
                if ({mem_we, mem_addr, mem_wmask} !== {t_we, t_addr, t_wmask} ||
                    (t_we && mem_wdata !== t_wdata)) begin
                    failures++;
                    $display("FAIL rnd_fields cyc=%0d got=%b %h %h %h exp=%b %h %h %h",
                             cyc, mem_we, mem_addr, mem_wmask, mem_wdata, t_we,
                             t_addr, t_wmask, t_wdata);
                end
                if (mem_ready) begin
                    hs_done = 1;
                    if (t_we) begin
                        for (int b = 0; b < 8; b++) begin
                            if (t_wmask[b]) mem[t_idx][8*b +: 8] = t_wdata[8*b +: 8];
                        end
                        t_rdata = '0;
                        rv_cyc  = cyc + 1;
                    end else begin
                        d       = int'($urandom_range(1, 5));
                        rd_pend = 1;
                        rd_due  = cyc + d;
                        rd_data = mem[t_idx];
                        t_rdata = rd_data;
                        rv_cyc  = cyc + d + 1;
                    end
                end
            end
            exp_rv  = busy && (cyc == rv_cyc);
            exp_irv = exp_rv && !own_ls;
            exp_lrv = exp_rv && own_ls;
            checks++;
            if ({if_rvalid, ls_rvalid, err} !== {exp_irv, exp_lrv, 1'b0}) begin
                failures++;
                $display("FAIL rnd_rvalid cyc=%0d got=%b%b err=%b exp=%b%b err=0",
                         cyc, if_rvalid, ls_rvalid, err, exp_irv, exp_lrv);
            end
            if (exp_irv) last_if = t_rdata;
            if (exp_lrv) last_ls = t_rdata;
            checks++;
            if ({if_rdata, ls_rdata} !== {last_if, last_ls}) begin
                failures++;
                $display("FAIL rnd_rdata cyc=%0d got=%h %h exp=%h %h", cyc,
                         if_rdata, ls_rdata, last_if, last_ls);
            end
            exp_stall = (if_req && !exp_irv) || (ls_req && !exp_lrv);
            checks++;
            if (stall_req !== exp_stall) begin
                failures++;
                $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall_req, exp_stall);
            end
            if (rd_pend && cyc == rd_due) rd_pend = 0;
            if (exp_rv) begin
                busy = 0;
                if (own_ls) ls_pend = 0;
                else if_pend = 0;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_if_read();
        test_priority();
        test_store();
        test_timeout();
        test_reset_mid();
        test_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
